rx_fifo_writer: RTL
===================

RX_FIFO_WRITER -- requirements
Module: rxFifoWriter

Interface
REQ-001 Parameter CNT_WIDTH, default 16, frame byte counter width; the status word is {rxStatus[15:0], byteCnt[15:0]}.
REQ-002 wrClk  in  1  write-domain clock; all logic SHALL be rising-edge wrClk.
REQ-003 wrHardReset_n  in  1  asynchronous, active-low reset.
REQ-004 wrFlush  in  1  synchronous flush, shared with the FIFO write-side flush.
REQ-005 rxFrameStart  in  1  pulse, first cycle of a frame; may coincide with rxByteValid for byte 0.
REQ-006 rxByteValid / rxByte  in  1 / 8  one received byte per asserted cycle; no backpressure.
REQ-007 rxFrameEnd  in  1  pulse after the last byte; may coincide with the last rxByteValid.
REQ-008 rxFrameAbort  in  1  pulse, frame terminated abnormally.
REQ-009 rxStatus  in  16  frame status, sampled on rxFrameEnd or rxFrameAbort.
REQ-010 fifoFull  in  1  FIFO full indication from the FIFO controller (wrClk domain).
REQ-011 fifoWrite  out  1  FIFO write strobe.
REQ-012 fifoWrData / fifoWrTag  out  32 / 2  word and tag; tags: 01 first word, 00 data, 10 good-end status, 11 bad-end status.
REQ-013 rxOverflow  out  1  one-cycle pulse per dropped word or frame.
REQ-014 writerBusy  out  1  high whenever state is not IDLE or a word is pending.

Function
REQ-015 Bytes SHALL pack little-endian: byte k of a word goes to fifoWrData[8k+7:8k].
REQ-016 The block SHALL hold one output word register plus a wordPending flag.
REQ-017 fifoWrite SHALL equal wordPending AND NOT fifoFull AND NOT wrFlush.
REQ-018 fifoWrite SHALL be the only combinational output; fifoWrData and fifoWrTag SHALL be driven from registers.
REQ-019 wordPending SHALL clear on the cycle after fifoWrite=1, unless a new word loads on that same edge.
REQ-020 A completed word (4th byte) SHALL load the output register on the next edge, so fifoWrite can assert 1 cycle after the 4th byte.
REQ-021 If a word completes while wordPending=1 and no write occurs that cycle, the new word SHALL be dropped.
REQ-022 On such a drop, rxOverflow SHALL pulse, the frame SHALL be marked bad, and the FSM SHALL go to DISCARD.
REQ-023 FSM states are IDLE, DATA, DISCARD and STATUS.
REQ-024 IDLE: bytes without rxFrameStart SHALL be ignored.
REQ-025 IDLE with rxFrameStart: go to DATA, clear byteCnt and the byte lane index, and set firstWord.
REQ-026 DATA: each rxByteValid SHALL increment byteCnt, saturating at all-ones.
REQ-027 The first word of a frame SHALL carry tag 01; later words SHALL carry tag 00.
REQ-028 DATA with rxFrameEnd: a partial word SHALL be zero-padded and queued (tag 01/00 by position), then the FSM SHALL go to STATUS.
REQ-029 DATA with rxFrameAbort: no partial word SHALL be queued; the frame SHALL be marked bad and the FSM SHALL go to STATUS.
REQ-030 DISCARD: bytes SHALL be ignored until rxFrameEnd or rxFrameAbort, then the FSM SHALL go to STATUS.
REQ-031 STATUS: once wordPending=0, the block SHALL load status word {rxStatus latched, byteCnt} with tag 10 (good) or 11 (bad), then return to IDLE.
REQ-032 rxStatus latched SHALL be the value captured on the terminating pulse.
REQ-033 A zero-byte frame (rxFrameStart and rxFrameEnd with no bytes) SHALL produce only a status word with byteCnt=0.
REQ-034 rxFrameStart in DATA, DISCARD or STATUS: the new frame SHALL be dropped and rxOverflow SHALL pulse.
REQ-035 In DATA or DISCARD, the current frame SHALL also be closed as bad (tag 11) through STATUS.
REQ-036 After a dropped frame, the FSM SHALL ignore input until the next rxFrameStart seen in IDLE.
REQ-037 rxFrameEnd and rxFrameAbort together: abort SHALL win.

Reset
REQ-038 On wrHardReset_n=0 the state SHALL be IDLE, wordPending=0, byteCnt=0 and the lane index=0.
REQ-039 During reset: fifoWrite=0, fifoWrData=0, fifoWrTag=00, rxOverflow=0, writerBusy=0.
REQ-040 wrFlush=1 SHALL produce the same state as reset on the next edge, with fifoWrite forced 0 that cycle.
REQ-041 Reset or flush mid-frame SHALL discard the partial word and the pending status with no rxOverflow pulse.

Verification
REQ-042 Frame of 6 bytes 0x11..0x66, status 0xA5A5, fifoFull=0 -> writes 0x44332211/01, 0x00006655/00, 0xA5A50006/10.
REQ-043 Frame of 4 bytes with fifoFull=1 held 3 cycles -> fifoWrite held off, the word is written once when full drops, rxOverflow=0.
REQ-044 fifoFull=1 held during a 12-byte frame -> first word held, second word dropped with rxOverflow pulse, final status tag 11 and byteCnt=8.
REQ-045 rxFrameAbort after 5 bytes, status 0x0001 -> writes first word (tag 01), then status 0x00010005/11, no partial word.
REQ-046 rxFrameStart during STATUS wait -> rxOverflow pulse; that frame produces no writes; the next frame is written normally.
REQ-047 wrFlush after 3 bytes -> no writes, writerBusy=0 next cycle; a following 1-byte frame writes 0x000000BB/01 then its status word.

Source files
------------

// File: rtl/rx_fifo_writer.sv
// Receive-side FIFO writer: packs bytes little-endian into tagged 32-bit words and
// closes every frame with a status word {latched rxStatus, byte count}.
module rx_fifo_writer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic        wrClk,
  input  logic        wrHardReset_n,
  input  logic        i_wrFlush,
  input  logic        i_rxFrameStart,
  input  logic        i_rxByteValid,
  input  logic [7:0]  i_rxByte,
  input  logic        i_rxFrameEnd,
  input  logic        i_rxFrameAbort,
  input  logic [15:0] i_rxStatus,
  input  logic        i_fifoFull,
  output logic        o_fifoWrite,
  output logic [31:0] o_fifoWrData,
  output logic [1:0]  o_fifoWrTag,
  output logic        o_rxOverflow,
  output logic        o_writerBusy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    DISCARD = 2'd2,
    STATUS  = 2'd3
  } state_t;

  localparam logic [1:0]           TAG_DATA  = 2'b00;
  localparam logic [1:0]           TAG_FIRST = 2'b01;
  localparam logic [1:0]           TAG_GOOD  = 2'b10;
  localparam logic [1:0]           TAG_BAD   = 2'b11;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  state_t               r_state, w_state;
  logic [CNT_WIDTH-1:0] r_byteCnt, w_byteCnt;
  logic [1:0]           r_lane, w_lane;
  logic [23:0]          r_assy, w_assy;
  logic                 r_firstWord, w_firstWord;
  logic                 r_bad, w_bad;
  logic [15:0]          r_status, w_status;
  logic                 r_wordPending, w_wordPending;
  logic [31:0]          r_wrData, w_wrData;
  logic [1:0]           r_wrTag, w_wrTag;
  logic                 r_rxOverflow, w_rxOverflow;
  logic                 r_writerBusy, w_writerBusy;

  logic                 w_write, w_canLoad, w_runFrame, w_take, w_wordDone, w_queue;
  logic [CNT_WIDTH-1:0] w_baseCnt, w_cntNext;
  logic [1:0]           w_baseLane, w_laneNext;
  logic [23:0]          w_baseAssy;
  logic                 w_baseFirst, w_baseBad;
  logic [31:0]          w_assyNext;
  logic [15:0]          w_cnt16;

  assign w_cnt16 = 16'(r_byteCnt);

  // Byte assembly; a start in IDLE begins from cleared frame context so byte 0 may ride along.
  always_comb begin
    w_write     = r_wordPending & ~i_fifoFull & ~i_wrFlush;
    w_canLoad   = ~r_wordPending | w_write;
    w_runFrame  = i_rxFrameStart ? (r_state == IDLE) : (r_state == DATA);
    w_baseCnt   = (r_state == IDLE) ? CNT_ZERO : r_byteCnt;
    w_baseLane  = (r_state == IDLE) ? 2'd0 : r_lane;
    w_baseAssy  = (r_state == IDLE) ? 24'h000000 : r_assy;
    w_baseFirst = (r_state == IDLE) ? 1'b1 : r_firstWord;
    w_baseBad   = (r_state == IDLE) ? 1'b0 : r_bad;
    w_take      = w_runFrame & i_rxByteValid;
    w_wordDone  = w_take & (w_baseLane == 2'd3);
    w_laneNext  = w_take ? (w_baseLane + 2'd1) : w_baseLane;
    w_cntNext   = (w_take && (w_baseCnt != CNT_MAX)) ? (w_baseCnt + CNT_ONE) : w_baseCnt;
    w_assyNext  = {8'h00, w_baseAssy};
    if (w_take) begin
      case (w_baseLane)
        2'd0:    w_assyNext[7:0]   = i_rxByte;
        2'd1:    w_assyNext[15:8]  = i_rxByte;
        2'd2:    w_assyNext[23:16] = i_rxByte;
        default: w_assyNext[31:24] = i_rxByte;
      endcase
    end else begin
      w_assyNext = {8'h00, w_baseAssy};
    end
    w_queue = w_runFrame &
              (w_wordDone | (i_rxFrameEnd & ~i_rxFrameAbort & (w_laneNext != 2'd0)));
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state       = r_state;
    w_byteCnt     = r_byteCnt;
    w_lane        = r_lane;
    w_assy        = r_assy;
    w_firstWord   = r_firstWord;
    w_bad         = r_bad;
    w_status      = r_status;
    w_wordPending = r_wordPending & ~w_write;
    w_wrData      = r_wrData;
    w_wrTag       = r_wrTag;
    w_rxOverflow  = 1'b0;
    if (i_wrFlush) begin
      w_state       = IDLE;
      w_byteCnt     = CNT_ZERO;
      w_lane        = 2'd0;
      w_assy        = 24'h000000;
      w_firstWord   = 1'b0;
      w_bad         = 1'b0;
      w_status      = 16'h0000;
      w_wordPending = 1'b0;
      w_wrData      = 32'h00000000;
      w_wrTag       = TAG_DATA;
    end else if (w_runFrame) begin
      w_state     = DATA;
      w_byteCnt   = w_cntNext;
      w_lane      = w_laneNext;
      w_assy      = w_wordDone ? 24'h000000 : w_assyNext[23:0];
      w_firstWord = w_baseFirst;
      w_bad       = w_baseBad;
      if (w_queue && w_canLoad) begin
        w_wrData      = w_assyNext;
        w_wrTag       = w_baseFirst ? TAG_FIRST : TAG_DATA;
        w_wordPending = 1'b1;
        w_firstWord   = 1'b0;
      end else if (w_queue) begin
        // Output register still occupied: the new word is lost, so the frame is unusable.
        w_rxOverflow = 1'b1;
        w_bad        = 1'b1;
        w_state      = DISCARD;
      end else begin
        w_firstWord = w_baseFirst;
      end
      if (i_rxFrameAbort) begin
        w_state  = STATUS;
        w_bad    = 1'b1;
        w_status = i_rxStatus;
      end else if (i_rxFrameEnd) begin
        w_state  = STATUS;
        w_status = i_rxStatus;
      end else begin
        w_status = r_status;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_state = IDLE;
        end
        DATA, DISCARD: begin
          if (i_rxFrameStart) begin
            w_rxOverflow = 1'b1;
            w_bad        = 1'b1;
            w_status     = i_rxStatus;
            w_state      = STATUS;
          end else if (i_rxFrameEnd || i_rxFrameAbort) begin
            w_status = i_rxStatus;
            w_state  = STATUS;
          end else begin
            w_state = DISCARD;
          end
        end
        STATUS: begin
          w_rxOverflow = i_rxFrameStart;
          if (!r_wordPending) begin
            w_wrData      = {r_status, w_cnt16};
            w_wrTag       = r_bad ? TAG_BAD : TAG_GOOD;
            w_wordPending = 1'b1;
            w_state       = IDLE;
          end else begin
            w_state = STATUS;
          end
        end
        default: begin
          w_state = IDLE;
        end
      endcase
    end
    w_writerBusy = (w_state != IDLE) | w_wordPending;
  end

  // State and output registers.
  always_ff @(posedge wrClk or negedge wrHardReset_n) begin
    if (!wrHardReset_n) begin
      r_state       <= IDLE;
      r_byteCnt     <= CNT_ZERO;
      r_lane        <= 2'd0;
      r_assy        <= 24'h000000;
      r_firstWord   <= 1'b0;
      r_bad         <= 1'b0;
      r_status      <= 16'h0000;
      r_wordPending <= 1'b0;
      r_wrData      <= 32'h00000000;
      r_wrTag       <= TAG_DATA;
      r_rxOverflow  <= 1'b0;
      r_writerBusy  <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_byteCnt     <= w_byteCnt;
      r_lane        <= w_lane;
      r_assy        <= w_assy;
      r_firstWord   <= w_firstWord;
      r_bad         <= w_bad;
      r_status      <= w_status;
      r_wordPending <= w_wordPending;
      r_wrData      <= w_wrData;
      r_wrTag       <= w_wrTag;
      r_rxOverflow  <= w_rxOverflow;
      r_writerBusy  <= w_writerBusy;
    end
  end

  assign o_fifoWrite  = w_write;
  assign o_fifoWrData = r_wrData;
  assign o_fifoWrTag  = r_wrTag;
  assign o_rxOverflow = r_rxOverflow;
  assign o_writerBusy = r_writerBusy;

endmodule
